miter_monitor_n: RTL and testbench
==================================

MITER_MONITOR_N -- requirements
Module: miter_monitor_n

Interface
REQ-001 SHALL have parameter NUM_INST, default 2, number of compared instances (2..8).
REQ-002 SHALL have parameter OUT_W, default 36, compared word width per instance (text_o 32 + cmd_o 4).
REQ-003 SHALL have parameter CNT_W, default 16, cycle-counter width.
REQ-004 SHALL have parameter HIST_D, default 8, history depth (power of 2), used only with MITER_HIST_EN.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port arm  input  1  start checking (pulse).
REQ-008 SHALL have port clr  input  1  return to IDLE and clear results (pulse).
REQ-009 SHALL have port inst_valid  input  NUM_INST  per-instance output-valid.
REQ-010 SHALL have port inst_out  input  NUM_INST*OUT_W  concatenated instance outputs, instance 0 in LSBs.
REQ-011 SHALL have port state_o  output  2  current FSM state.
REQ-012 SHALL have port diverged  output  1  sticky divergence flag.
REQ-013 SHALL have port div_mask  output  NUM_INST  instances differing from instance 0 at first divergence; bit 0 always 0.
REQ-014 SHALL have port div_cycle  output  CNT_W  cycle count at first divergence.
REQ-015 SHALL have port cmp_count  output  CNT_W  number of compare events since arm, saturating.
REQ-016 SHALL have ports hist_idx  input  log2(HIST_D) and hist_data  output  2*OUT_W  history read (instance-0 word, first-differing-instance word).

Function
REQ-017 SHALL register inst_valid/inst_out into a one-stage input pipeline every cycle; all comparisons use registered values.
REQ-018 SHALL implement states IDLE(0), ARMED(1), DIVERGED(2); code 3 unreachable, decodes to IDLE.
REQ-019 SHALL transition IDLE->ARMED on arm; ARMED->DIVERGED on divergence; ARMED/DIVERGED->IDLE on clr; clr wins over arm and divergence in the same cycle.
REQ-020 SHALL define a compare event in ARMED as: all registered valids 1 (data compared) or valids not all equal (control divergence).
REQ-021 SHALL flag divergence when valids disagree or, with all valid, any instance word != instance-0 word; all-valid-low cycles are not compare events.
REQ-022 SHALL set diverged, div_mask, div_cycle in the cycle the state enters DIVERGED (latency: input edge +2 cycles); for valid disagreement div_mask marks instances whose valid differs from instance 0.
REQ-023 SHALL hold diverged, div_mask, div_cycle frozen in DIVERGED; later mismatches ignored.
REQ-024 SHALL count cycles in ARMED in a CNT_W counter cleared on arm, saturating at all-ones; div_cycle captures its value at the divergent compare.
REQ-025 SHALL increment cmp_count per compare event in ARMED, saturating at all-ones, frozen outside ARMED.
REQ-026 SHALL ignore arm while ARMED or DIVERGED.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set state IDLE, diverged 0, div_mask 0, div_cycle 0, cmp_count 0, counters 0, input pipeline 0, history pointer 0, hist_data 0.
REQ-028 SHALL, on reset mid-ARMED, discard all progress; checking resumes only after a new arm.

Configuration
REQ-029 SHALL with MITER_HIST_EN defined keep a HIST_D-deep circular buffer of (instance-0 word, lowest-index differing or instance-1 word) written per compare event in ARMED, frozen on entry to DIVERGED, cleared by arm; hist_idx 0 = most recent entry; hist_data combinational from hist_idx.
REQ-030 SHALL without MITER_HIST_EN instantiate no buffer, ignore hist_idx, and tie hist_data to 0.

Structure
REQ-031 SHALL place the state enum (IDLE/ARMED/DIVERGED) and default parameter constants in package miter_pkg.
REQ-032 SHALL implement the history buffer as sub-module miter_hist_buf, instantiated only under MITER_HIST_EN.

Verification
REQ-033 SHALL test: NUM_INST=2, arm, 20 cycles identical valid words 0xA5A5A5A5_3 -> state ARMED, diverged 0, cmp_count 20.
REQ-034 SHALL test: NUM_INST=4, arm at cycle 0, instance 2 word differs at input cycle 5 -> diverged 1 two cycles later, div_mask 4'b0100, div_cycle 5, state DIVERGED.
REQ-035 SHALL test: inst_valid 2'b01 while ARMED -> div_mask 2'b10, diverged 1; subsequent mismatches leave captures unchanged.
REQ-036 SHALL test: clr and divergence in same cycle -> state IDLE, diverged 0; arm and clr together from IDLE -> stays IDLE.
REQ-037 SHALL test: CNT_W=4, 20 cycles ARMED without mismatch -> cmp_count 15 (saturated); rst_n low mid-ARMED -> all outputs 0 immediately, state IDLE.
REQ-038 SHALL test (MITER_HIST_EN): HIST_D=8, 10 compare events then divergence -> hist_idx 0 returns divergent pair, hist_idx 7 returns event 3.

Source files
------------

// File: rtl/miter_pkg.sv
// Shared state encoding and default sizing for the miter monitor.
package miter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DIV   = 2'd2
  } miter_state_e;

  localparam int DEF_NUM_INST = 2;
  localparam int DEF_OUT_W    = 36;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_HIST_D   = 8;

endpackage

// File: rtl/miter_hist_buf.sv
// Circular history of compared word pairs; idx 0 reads the newest entry.
module miter_hist_buf #(
  parameter int W  = 72,
  parameter int D  = 8,
  localparam int AW = $clog2(D)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] idx_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] raddr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[ptr_q] <= wdata_i;
      ptr_q        <= ptr_q + 1'b1;
    end
  end

  // ptr_q is the next free slot, so the newest entry sits one below it
  assign raddr   = ptr_q - idx_i - 1'b1;
  assign rdata_o = mem_q[raddr];

endmodule

// File: rtl/miter_monitor_n.sv
// Lock-step miter comparing N instance outputs against instance 0.
// MITER_HIST_EN adds a history buffer; hist_data = {other word, inst-0 word}.
module miter_monitor_n
  import miter_pkg::*;
#(
  parameter int NUM_INST = DEF_NUM_INST,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HIST_D   = DEF_HIST_D,
  localparam int HW      = $clog2(HIST_D)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm,
  input  logic                      clr,
  input  logic [NUM_INST-1:0]       inst_valid,
  input  logic [NUM_INST*OUT_W-1:0] inst_out,
  output logic [1:0]                state_o,
  output logic                      diverged,
  output logic [NUM_INST-1:0]       div_mask,
  output logic [CNT_W-1:0]          div_cycle,
  output logic [CNT_W-1:0]          cmp_count,
  input  logic [HW-1:0]             hist_idx,
  output logic [2*OUT_W-1:0]        hist_data
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [NUM_INST-1:0]       v_q;
  logic [NUM_INST*OUT_W-1:0] d_q;
  miter_state_e              st_q;
  logic                      div_q;
  logic [NUM_INST-1:0]       mask_q;
  logic [CNT_W-1:0]          dcyc_q;
  logic [CNT_W-1:0]          cyc_q;
  logic [CNT_W-1:0]          cmp_q;

  logic                all_v;
  logic                ctrl_div;
  logic                evt;
  logic                is_div;
  logic [OUT_W-1:0]    w0;
  logic [NUM_INST-1:0] data_mask;
  logic [NUM_INST-1:0] evt_mask;

  always_comb begin
    w0        = d_q[OUT_W-1:0];
    data_mask = '0;
    for (int i = 1; i < NUM_INST; i++)
      data_mask[i] = d_q[i*OUT_W +: OUT_W] != w0;
    all_v    = &v_q;
    ctrl_div = (|v_q) & ~all_v;
    evt      = all_v | ctrl_div;
    is_div   = ctrl_div | (all_v & (|data_mask));
    evt_mask = ctrl_div ? (v_q ^ {NUM_INST{v_q[0]}}) : data_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      d_q    <= '0;
      st_q   <= ST_IDLE;
      div_q  <= 1'b0;
      mask_q <= '0;
      dcyc_q <= '0;
      cyc_q  <= '0;
      cmp_q  <= '0;
    end else begin
      v_q <= inst_valid;
      d_q <= inst_out;
      if (clr) begin
        st_q   <= ST_IDLE;
        div_q  <= 1'b0;
        mask_q <= '0;
        dcyc_q <= '0;
        cyc_q  <= '0;
        cmp_q  <= '0;
      end else begin
        case (st_q)
          ST_ARMED: begin
            if (cyc_q != CMAX) cyc_q <= cyc_q + 1'b1;
            if (evt && cmp_q != CMAX) cmp_q <= cmp_q + 1'b1;
            if (is_div) begin
              st_q   <= ST_DIV;
              div_q  <= 1'b1;
              mask_q <= evt_mask;
              dcyc_q <= cyc_q;
            end
          end
          ST_DIV: begin
          end
          default: begin
            if (arm) begin
              st_q   <= ST_ARMED;
              div_q  <= 1'b0;
              mask_q <= '0;
              dcyc_q <= '0;
              cyc_q  <= '0;
              cmp_q  <= '0;
            end
          end
        endcase
      end
    end
  end

  assign state_o   = (st_q == ST_ARMED || st_q == ST_DIV) ? st_q : ST_IDLE;
  assign diverged  = div_q;
  assign div_mask  = mask_q;
  assign div_cycle = dcyc_q;
  assign cmp_count = cmp_q;

`ifdef MITER_HIST_EN
  logic [OUT_W-1:0] wsel;
  logic             arm_ok;
  logic             hist_we;

  // lowest differing instance wins; instance 1 when nothing differs
  always_comb begin
    wsel = d_q[OUT_W +: OUT_W];
    for (int i = NUM_INST-1; i >= 1; i--)
      if (evt_mask[i]) wsel = d_q[i*OUT_W +: OUT_W];
  end

  assign arm_ok  = arm & ~clr & (st_q != ST_ARMED) & (st_q != ST_DIV);
  assign hist_we = (st_q == ST_ARMED) & evt & ~clr;

  miter_hist_buf #(
    .W (2*OUT_W),
    .D (HIST_D)
  ) u_hist (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (arm_ok),
    .we_i    (hist_we),
    .wdata_i ({wsel, w0}),
    .idx_i   (hist_idx),
    .rdata_o (hist_data)
  );
`else
  logic unused_hist;
  assign unused_hist = ^hist_idx;
  assign hist_data   = '0;
`endif

endmodule

// File: tb/tb_miter_monitor_n.sv
// Directed bench for miter_monitor_n: two-, four-instance and narrow-counter builds.
module tb_miter_monitor_n;

  localparam logic [35:0] WA = 36'hA5A5A5A53;
  localparam logic [35:0] WB = 36'h123456789;
  localparam logic [35:0] WC = 36'h0DEADBEEF;

  logic         clk = 1'b0;
  logic         rst_n, arm, clr;
  logic [1:0]   v2;
  logic [71:0]  o2;
  logic [3:0]   v4;
  logic [143:0] o4;
  logic [2:0]   hidx;

  logic [1:0]  st2, st2s, st4;
  logic        div2, div2s, div4;
  logic [1:0]  mask2, mask2s;
  logic [3:0]  mask4;
  logic [15:0] dcyc2, cmp2, dcyc4, cmp4;
  logic [3:0]  dcyc2s, cmp2s;
  logic [71:0] hist2, hist2s, hist4;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  miter_monitor_n #(.NUM_INST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clr(clr),
    .inst_valid(v2), .inst_out(o2), .state_o(st2),
    .diverged(div2), .div_mask(mask2), .div_cycle(dcyc2),
    .cmp_count(cmp2), .hist_idx(hidx), .hist_data(hist2)
  );

  miter_monitor_n #(.NUM_INST(2), .CNT_W(4)) dut2s (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clr(clr),
    .inst_valid(v2), .inst_out(o2), .state_o(st2s),
    .diverged(div2s), .div_mask(mask2s), .div_cycle(dcyc2s),
    .cmp_count(cmp2s), .hist_idx(hidx), .hist_data(hist2s)
  );

  miter_monitor_n #(.NUM_INST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clr(clr),
    .inst_valid(v4), .inst_out(o4), .state_o(st4),
    .diverged(div4), .div_mask(mask4), .div_cycle(dcyc4),
    .cmp_count(cmp4), .hist_idx(hidx), .hist_data(hist4)
  );

  task automatic check(input string tag, input logic [143:0] got,
                       input logic [143:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; clr = 1'b0;
    v2 = '0; o2 = '0; v4 = '0; o4 = '0; hidx = '0;
    tick(2);
    check("rst_st2", st2, 0);
    check("rst_div4", div4, 0);
    check("rst_cmp2", cmp2, 0);
    check("rst_mask4", mask4, 0);
    rst_n = 1'b1;
    tick(1);

    // 20 identical compares; narrow counter saturates
    v2 = 2'b11; o2 = {WA, WA};
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(20);
    check("eq_st2", st2, 1);
    check("eq_div2", div2, 0);
    check("eq_cmp2", cmp2, 20);
    check("sat_cmp2s", cmp2s, 15);
    check("sat_st2s", st2s, 1);
    check("novalid_cmp4", cmp4, 0);
    check("novalid_st4", st4, 1);

    // asynchronous reset while armed
    rst_n = 1'b0; #1;
    check("arst_st2s", st2s, 0);
    check("arst_cmp2s", cmp2s, 0);
    check("arst_div2s", div2s, 0);
    check("arst_st2", st2, 0);
    check("arst_cmp2", cmp2, 0);
    rst_n = 1'b1;
    tick(3);
    check("noarm_st2", st2, 0);
    check("noarm_cmp2", cmp2, 0);

    // four instances, instance 2 differs at input cycle 5
    v4 = 4'hF; o4 = {4{WB}};
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(4);
    o4[72 +: 36] = WC;
    tick(1);
    check("lat_div4", div4, 0);
    check("lat_st4", st4, 1);
    o4 = {4{WB}};
    tick(1);
    check("d4_div", div4, 1);
    check("d4_mask", mask4, 4'b0100);
    check("d4_cyc", dcyc4, 5);
    check("d4_st", st4, 2);
    check("d4_cmp", cmp4, 6);
    o4[36 +: 36] = WC;
    tick(2);
    check("frz_mask4", mask4, 4'b0100);
    check("frz_cyc4", dcyc4, 5);
    check("frz_cmp4", cmp4, 6);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_st4", st4, 0);
    check("clr_div4", div4, 0);
    check("clr_mask4", mask4, 0);

    // valid disagreement on two instances
    v2 = 2'b11; o2 = {WA, WA};
    arm = 1'b1; tick(1); arm = 1'b0;
    v2 = 2'b01;
    tick(2);
    check("vd_div2", div2, 1);
    check("vd_mask2", mask2, 2'b10);
    check("vd_st2", st2, 2);
    check("vd_cyc2", dcyc2, 1);
    check("vd_cmp2", cmp2, 2);
    v2 = 2'b11; o2 = {WC, WA};
    tick(3);
    check("vd_frz_mask2", mask2, 2'b10);
    check("vd_frz_cyc2", dcyc2, 1);
    check("vd_frz_cmp2", cmp2, 2);
    clr = 1'b1; tick(1); clr = 1'b0;

    // clear beats a same-cycle divergence; clear beats arm
    v2 = 2'b11; o2 = {WA, WA};
    arm = 1'b1; tick(1); arm = 1'b0;
    o2 = {WC, WA};
    tick(1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("cd_st2", st2, 0);
    check("cd_div2", div2, 0);
    check("cd_mask2", mask2, 0);
    arm = 1'b1; clr = 1'b1; tick(1); arm = 1'b0; clr = 1'b0;
    check("ac_st2", st2, 0);
    check("ac_cmp2", cmp2, 0);

`ifdef MITER_HIST_EN
    v4 = 4'hF; o4 = '0;
    arm = 1'b1; tick(1); arm = 1'b0;
    for (int k = 1; k < 10; k++) begin
      o4 = {4{36'(k)}};
      tick(1);
    end
    o4 = {36'h200, 36'h100, 36'h100, 36'h100};
    tick(1);
    o4 = {4{36'h3FF}};
    tick(3);
    check("h_st4", st4, 2);
    hidx = 3'd0; #1;
    check("h_idx0", hist4, {36'h200, 36'h100});
    hidx = 3'd1; #1;
    check("h_idx1", hist4, {36'd9, 36'd9});
    hidx = 3'd7; #1;
    check("h_idx7", hist4, {36'd3, 36'd3});
`else
    hidx = 3'd0; #1;
    check("nh_idx0", hist4, 0);
    hidx = 3'd5; #1;
    check("nh_idx5", hist2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
